otfs_modulator: RTL and testbench

OTFS_MODULATOR -- requirements
Module: otfs_modulator

---
 rtl/otfs_modulator.sv | 164 ++++++++++++++++
 tb/tb_otfs_modulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/otfs_modulator.sv
// OTFS modulator front end: records an N x N delay-Doppler grid, configures the IFFT core for
// an inverse transform, then streams the grid out column-wise (transposed) as N-point frames.
module otfs_modulator #(
  parameter int unsigned LOG2N = 6
) (
  input  logic        Clk,
  input  logic        Srst,
  input  logic        Start,
  input  logic        QAMDataValid,
  input  logic [15:0] QAMDataRe,
  input  logic [15:0] QAMDataIm,
  output logic [7:0]  CfgTdata,
  output logic        CfgTvalid,
  input  logic        CfgTready,
  output logic [31:0] IfftTdata,
  output logic        IfftTvalid,
  input  logic        IfftTready,
  output logic        IfftTlast,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned AW    = 2 * LOG2N;
  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StIdle, StConfig, StRecord, StFeed} state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_done_q, rd_done_d;
  logic [AW-1:0] rd_addr;
  logic          wr_en, rd_en, pop;
  logic [1:0]    occ;

  logic [31:0]   mem [Depth];
  logic [31:0]   ram_q;

  logic          pend_v_q, pend_last_q, pend_fin_q;
  logic          out_v_q, out_v_d, out_last_q, out_last_d, out_fin_q, out_fin_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          skid_v_q, skid_v_d, skid_last_q, skid_last_d, skid_fin_q, skid_fin_d;
  logic [31:0]   skid_data_q, skid_data_d;
  logic          done_q;

  // rd_cnt is the output index j; row (j mod N) is its low half and selects the RAM row.
  assign rd_addr = {rd_cnt_q[LOG2N-1:0], rd_cnt_q[AW-1:LOG2N]};
  assign wr_en   = (state_q == StRecord) && QAMDataValid;
  assign pop     = out_v_q && IfftTready;
  assign occ     = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_v_q};
  // Keep at most two samples in flight (output + skid) counting the RAM read in progress.
  assign rd_en   = (state_q == StFeed) && !rd_done_q && ((occ - {1'b0, pop}) < 2'd2);

  always_ff @(posedge Clk) begin
    if (Srst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (Start) state_d = StConfig;
      StConfig: if (CfgTready) state_d = StRecord;
      StRecord: if (wr_en && (&wr_cnt_q)) state_d = StFeed;
      StFeed:   if (pop && out_fin_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_cnt_d  = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_done_d = rd_done_q;
    if (state_q != StFeed) begin
      rd_cnt_d  = '0;
      rd_done_d = 1'b0;
    end else if (rd_en) begin
      rd_cnt_d  = rd_cnt_q + 1'b1;
      rd_done_d = &rd_cnt_q;
    end
  end

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_fin_d   = out_fin_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_fin_d  = skid_fin_q;
    if (pop) begin
      out_v_d    = skid_v_q;
      out_data_d = skid_data_q;
      out_last_d = skid_last_q;
      out_fin_d  = skid_fin_q;
      skid_v_d   = 1'b0;
    end
    if (pend_v_q) begin
      if (!out_v_d) begin
        out_v_d    = 1'b1;
        out_data_d = ram_q;
        out_last_d = pend_last_q;
        out_fin_d  = pend_fin_q;
      end else begin
        skid_v_d    = 1'b1;
        skid_data_d = ram_q;
        skid_last_d = pend_last_q;
        skid_fin_d  = pend_fin_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_cnt_q] <= {QAMDataIm, QAMDataRe};
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (Srst) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_last_q <= 1'b0;
      pend_fin_q  <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_fin_q   <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_fin_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_done_q   <= rd_done_d;
      pend_v_q    <= rd_en;
      pend_last_q <= &rd_cnt_q[LOG2N-1:0];
      pend_fin_q  <= &rd_cnt_q;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_fin_q   <= out_fin_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_fin_q  <= skid_fin_d;
      done_q      <= pop && out_fin_q;
    end
  end

  assign CfgTdata   = 8'h00;
  assign CfgTvalid  = (state_q == StConfig);
  assign IfftTdata  = out_data_q;
  assign IfftTvalid = out_v_q;
  assign IfftTlast  = out_last_q;
  assign Busy       = (state_q != StIdle);
  assign Done       = done_q;

endmodule

// File: tb/tb_otfs_modulator.sv
// Scoreboard bench for otfs_modulator: expected transposed samples are queued per frame and
// checked by an independent monitor on every output transfer.
module tb_otfs_modulator;

  localparam int N  = 64;
  localparam int NN = N * N;

  logic        Clk = 1'b0;
  logic        Srst = 1'b1;
  logic        Start = 1'b0;
  logic        QAMDataValid = 1'b0;
  logic [15:0] QAMDataRe = '0;
  logic [15:0] QAMDataIm = '0;
  logic [7:0]  CfgTdata;
  logic        CfgTvalid;
  logic        CfgTready = 1'b1;
  logic [31:0] IfftTdata;
  logic        IfftTvalid;
  logic        IfftTready = 1'b1;
  logic        IfftTlast;
  logic        Busy;
  logic        Done;

  otfs_modulator #(.LOG2N(6)) dut (
    .Clk(Clk), .Srst(Srst), .Start(Start), .QAMDataValid(QAMDataValid),
    .QAMDataRe(QAMDataRe), .QAMDataIm(QAMDataIm), .CfgTdata(CfgTdata), .CfgTvalid(CfgTvalid),
    .CfgTready(CfgTready), .IfftTdata(IfftTdata), .IfftTvalid(IfftTvalid),
    .IfftTready(IfftTready), .IfftTlast(IfftTlast), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [33:0] exp_q[$];  // {final, last, Im, Re}
  bit   feed_phase = 0;
  bit   frame_done = 0;
  int   xfer_cnt = 0, tlast_cnt = 0, cfg_cnt = 0, done_cnt = 0;
  int   first_cyc = 0, last_cyc = 0, fin_cyc = -10;
  int   idle_run = 0, last_idle = 0;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [33:0] e;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Srst) begin
        if (prev_stall)
          check("stall_hold", {IfftTvalid, IfftTlast, IfftTdata}, {1'b1, prev_last, prev_data});
        if (CfgTvalid && CfgTready) begin
          cfg_cnt++;
          check("cfg_word", CfgTdata, 8'h00);
        end
        if (Done) begin
          done_cnt++;
          check("done_timing", {cyc, IfftTvalid}, {fin_cyc + 1, 1'b0});
        end
        if (IfftTvalid && IfftTready) begin
          check("expected_out", feed_phase && (exp_q.size() != 0), 1);
          if (feed_phase && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sample", {IfftTlast, IfftTdata}, e[32:0]);
            if (xfer_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            xfer_cnt++;
            if (IfftTlast) tlast_cnt++;
            if (e[33]) begin
              fin_cyc    = cyc;
              frame_done = 1;
            end
          end
        end
      end
      prev_stall = IfftTvalid && !IfftTready && !Srst;
      prev_data  = IfftTdata;
      prev_last  = IfftTlast;
      if (!Busy) idle_run++;
      else if (idle_run > 0) begin
        last_idle = idle_run;
        idle_run  = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, {Busy, CfgTvalid, CfgTdata, IfftTvalid, IfftTlast, IfftTdata, Done}, 64'h0);
  endtask

  // mode 0: Re=k, mode 1: Re=4095-k; Im=-Re in both.
  task automatic run_frame(input int mode, input bit rnd, input bit cfg_stall, input bit spur,
                           input int abort_at);
    int cfg_base;
    int budget;
    xfer_cnt   = 0;
    tlast_cnt  = 0;
    frame_done = 0;
    feed_phase = 0;
    cfg_base   = cfg_cnt;
    for (int j = 0; j < NN; j++) begin
      int          a;
      logic [15:0] r;
      a = (j % N) * N + j / N;
      r = 16'(mode != 0 ? NN - 1 - a : a);
      exp_q.push_back({j == NN - 1, (j % N) == N - 1, -r, r});
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    if (cfg_stall) begin
      CfgTready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        QAMDataValid = 1'b1;
        QAMDataRe    = 16'h7a00 + 16'(i);
        QAMDataIm    = 16'h5500;
        tick();
        check("cfg_hold", CfgTvalid, 1);
      end
      QAMDataValid = 1'b0;
      CfgTready    = 1'b1;
    end
    tick();
    check("cfg_handshake", {Busy, CfgTvalid}, 2'b10);
    for (int k = 0; k < NN; k++) begin
      logic [15:0] r;
      r            = 16'(mode != 0 ? NN - 1 - k : k);
      QAMDataValid = 1'b1;
      QAMDataRe    = r;
      QAMDataIm    = -r;
      Start        = spur && (k == 100);
      tick();
      Start        = 1'b0;
      if (k % 97 == 5) begin
        QAMDataValid = 1'b0;
        tick();
      end
    end
    QAMDataValid = 1'b0;
    feed_phase   = 1;
    check("cfg_once", cfg_cnt - cfg_base, 1);
    budget = 0;
    while (!frame_done && budget < 20000) begin
      if (abort_at > 0 && xfer_cnt >= abort_at) begin
        IfftTready = 1'b0;
        Srst       = 1'b1;
        exp_q.delete();
        feed_phase = 0;
        tick();
        check_reset_outputs("abort_reset");
        Srst       = 1'b0;
        IfftTready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("abort_idle", {Busy, IfftTvalid}, 2'b00);
        return;
      end
      IfftTready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      Start        = spur && (budget % 50 == 3);
      QAMDataValid = spur && (budget % 3 == 0);
      QAMDataRe    = 16'h1234;
      QAMDataIm    = 16'h4321;
      tick();
      Start        = 1'b0;
      QAMDataValid = 1'b0;
      budget++;
    end
    IfftTready = 1'b1;
    check("frame_done", frame_done, 1);
    check("frame_count", {xfer_cnt, tlast_cnt}, {NN, N});
    check("done_pulse", {Done, Busy}, 2'b10);
    if (!rnd) check("no_bubbles", last_cyc - first_cyc, NN - 1);
    exp_q.delete();
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset_state");
    Srst = 1'b0;
    tick();
    check_reset_outputs("idle_state");
    run_frame(0, 0, 0, 0, 0);   // baseline, full rate
    tick();
    run_frame(0, 1, 0, 0, 0);   // random backpressure
    tick();
    run_frame(0, 0, 1, 1, 0);   // config stall, spurious Start/symbols
    tick();
    run_frame(0, 1, 0, 0, 1000);
    run_frame(1, 0, 0, 0, 0);   // fresh frame after reset
    tick();
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0);   // back-to-back with the previous one
    check("busy_gap", last_idle, 1);
    for (int i = 0; i < 5; i++) tick();
    check("done_total", done_cnt, 6);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
